// File: rtl/rv_dbus_sram.sv
// rv_dbus_sram: word-organised D-bus SRAM slave with wait states and byte lanes.
// Define DBUS_SRAM_ERR_EN to flag out-of-range, misaligned and reserved-size accesses on berr.
module rv_dbus_sram #(
  parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bstart,
  input  logic        breq,
  input  logic        ttype,
  input  logic [2:0]  tsize,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        bdone,
  output logic        berr
);
  localparam int AW = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic ttype_q, ttype_d, berr_q, berr_d;
  logic [1:0] size_q, size_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [31:0] mem [DEPTH_WORDS];
  logic idle, accept, commit, is_wr, err, unused_bits;
  logic [1:0] sz, sz_e, off;
  logic [31:0] a, wd, rel, lane_m, cur, rd_word, wr_word;
  logic [AW-1:0] idx;
  // In IDLE the live request is used so a zero-wait access can commit on its acceptance edge.
  assign idle    = state_q == IDLE;
  assign accept  = idle && bstart && breq;
  assign a       = idle ? addr : addr_q;
  assign wd      = idle ? wdata : wdata_q;
  assign is_wr   = idle ? ttype : ttype_q;
  assign sz      = idle ? tsize[1:0] : size_q;
  assign addr_d  = a;
  assign wdata_d = wd;
  assign ttype_d = is_wr;
  assign size_d  = sz;
  assign rel     = a - BASE_ADDR;
  assign idx     = rel[AW+1:2];
  assign sz_e    = (&sz) ? 2'd2 : sz;
  assign off     = (sz_e == 2'd2) ? 2'd0 : (sz_e == 2'd1) ? {a[1], 1'b0} : a[1:0];
  assign lane_m  = (sz_e == 2'd2) ? 32'hFFFF_FFFF : (sz_e == 2'd1) ? 32'h0000_FFFF : 32'h0000_00FF;
  assign cur     = mem[idx];
  assign rd_word = (cur >> {off, 3'b000}) & lane_m;
  assign wr_word = (cur & ~(lane_m << {off, 3'b000})) | ((wd & lane_m) << {off, 3'b000});
`ifdef DBUS_SRAM_ERR_EN
  assign err = (a < BASE_ADDR) || (rel[31:AW+2] != '0) || (&sz) ||
               (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
  assign unused_bits = tsize[2];
`else
  assign err = 1'b0;
  assign unused_bits = ^{tsize[2], rel[31:AW+2], rel[1:0]};
`endif
  // Reset gates the commit so nothing is written while rst_n is low.
  assign commit  = rst_n && state_d == RESP && state_q != RESP;
  assign rdata_d = commit ? ((is_wr || err) ? 32'h0 : rd_word) : rdata_q;
  assign berr_d  = commit ? err : berr_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ttype_q <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ttype_q <= ttype_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      berr_q  <= berr_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (accept) begin
        cnt_d   = 4'(WAIT_STATES);
        state_d = (WAIT_STATES == 0) ? RESP : BUSY;
      end
      BUSY: begin
        cnt_d   = cnt_q - 4'd1;
        state_d = (cnt_q == 4'd1) ? RESP : BUSY;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    bdone = state_q == RESP;
    berr  = bdone && berr_q;
    rdata = rdata_q;
  end
  always_ff @(posedge clk) if (commit && is_wr && !err) mem[idx] <= wr_word;
endmodule

// File: tb/tb_rv_dbus_sram.sv
// tb_rv_dbus_sram: vector table and scoreboard bench for rv_dbus_sram.
// Expectations follow DBUS_SRAM_ERR_EN when it is defined.
module tb_rv_dbus_sram;
`ifdef DBUS_SRAM_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif
  typedef struct {
    logic        tt;
    logic [2:0]  sz;
    logic [31:0] ad;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        e;
  } vec_t;
  typedef struct {
    logic [31:0] rd;
    logic        e;
    int          c;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0, bstart = 1'b0, bstart0 = 1'b0, bstart3 = 1'b0, breq = 1'b0, ttype = 1'b0;
  logic [2:0] tsize = 3'd0;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic [31:0] rdata, rdata0, rdata3;
  logic bdone, bdone0, bdone3, berr, berr0, berr3;
  int cyc = 0, n_chk = 0, n_fail = 0;
  exp_t sb[$];
  vec_t vec[22];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  rv_dbus_sram #(.WAIT_STATES(1)) dut (.clk(clk), .rst_n(rst_n), .bstart(bstart), .breq(breq), .ttype(ttype),
    .tsize(tsize), .addr(addr), .wdata(wdata), .rdata(rdata), .bdone(bdone), .berr(berr));
  rv_dbus_sram #(.WAIT_STATES(0)) dut0 (.clk(clk), .rst_n(rst_n), .bstart(bstart0), .breq(breq), .ttype(ttype),
    .tsize(tsize), .addr(addr), .wdata(wdata), .rdata(rdata0), .bdone(bdone0), .berr(berr0));
  rv_dbus_sram #(.WAIT_STATES(3)) dut3 (.clk(clk), .rst_n(rst_n), .bstart(bstart3), .breq(breq), .ttype(ttype),
    .tsize(tsize), .addr(addr), .wdata(wdata), .rdata(rdata3), .bdone(bdone3), .berr(berr3));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  always @(negedge clk) if (rst_n && bdone) begin
    exp_t e;
    if (sb.size() == 0) chk("unexpected_bdone", 32'd1, 32'd0);
    else begin
      e = sb.pop_front();
      chk("rdata", rdata, e.rd);
      chk("berr", {31'h0, berr}, {31'h0, e.e});
      chk("latency", 32'(cyc - e.c), 32'd2);
    end
  end
  task automatic issue(input logic tt, input logic [2:0] sz, input logic [31:0] ad, input logic [31:0] wd,
                       input logic [31:0] rd, input logic e, input bit push);
    ttype = tt; tsize = sz; addr = ad; wdata = wd; bstart = 1'b1; breq = 1'b1;
    if (push) sb.push_back('{rd, e, cyc});
  endtask
  task automatic wait_done();
    bit got = 1'b0;
    for (int k = 0; k < 30 && !got; k++) begin
      @(negedge clk);
      got = bdone;
    end
    if (!got) chk("bdone_timeout", 32'd0, 32'd1);
  endtask
  task automatic xact(input vec_t v);
    @(negedge clk);
    issue(v.tt, v.sz, v.ad, v.wd, v.rd, v.e, 1'b1);
    @(negedge clk);
    ttype = ~v.tt; tsize = 3'($urandom); addr = $urandom; wdata = $urandom;
    wait_done();
    bstart = 1'b0;
  endtask
  task automatic lat_run(input int w, input logic tt, input logic [31:0] wd, input logic [31:0] exp_rd);
    int c;
    bit got = 1'b0;
    @(negedge clk);
    ttype = tt; tsize = 3'd2; addr = 32'h2000_0040; wdata = wd; breq = 1'b1;
    if (w == 0) bstart0 = 1'b1; else bstart3 = 1'b1;
    c = cyc;
    for (int k = 0; k < 30 && !got; k++) begin
      @(negedge clk);
      got = (w == 0) ? bdone0 : bdone3;
    end
    bstart0 = 1'b0; bstart3 = 1'b0;
    chk($sformatf("latency_ws%0d", w), got ? 32'(cyc - c) : 32'hFFFF_FFFF, 32'(w + 1));
    chk($sformatf("rdata_ws%0d", w), (w == 0) ? rdata0 : rdata3, exp_rd);
    chk($sformatf("berr_ws%0d", w), {31'h0, (w == 0) ? berr0 : berr3}, 32'h0);
  endtask
  initial begin
    vec[0]  = '{1'b1, 3'b010, 32'h2000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0};
    vec[1]  = '{1'b0, 3'b010, 32'h2000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0};
    vec[2]  = '{1'b1, 3'b010, 32'h2000_0020, 32'h1122_3344, 32'h0, 1'b0};
    vec[3]  = '{1'b1, 3'b000, 32'h2000_0022, 32'hFFFF_FFAA, 32'h0, 1'b0};
    vec[4]  = '{1'b0, 3'b010, 32'h2000_0020, 32'h0, 32'h11AA_3344, 1'b0};
    vec[5]  = '{1'b0, 3'b001, 32'h2000_0022, 32'h0, 32'h0000_11AA, 1'b0};
    vec[6]  = '{1'b0, 3'b000, 32'h2000_0023, 32'h0, 32'h0000_0011, 1'b0};
    vec[7]  = '{1'b0, 3'b100, 32'h2000_0021, 32'h0, 32'h0000_0033, 1'b0};
    vec[8]  = '{1'b0, 3'b101, 32'h2000_0020, 32'h0, 32'h0000_3344, 1'b0};
    vec[9]  = '{1'b1, 3'b010, 32'h2000_0024, 32'h0, 32'h0, 1'b0};
    vec[10] = '{1'b1, 3'b001, 32'h2000_0026, 32'hFFFF_5566, 32'h0, 1'b0};
    vec[11] = '{1'b0, 3'b010, 32'h2000_0024, 32'h0, 32'h5566_0000, 1'b0};
    vec[12] = '{1'b1, 3'b010, 32'h2000_0FFC, 32'hCAFE_F00D, 32'h0, 1'b0};
    vec[13] = '{1'b0, 3'b000, 32'h2000_0FFF, 32'h0, 32'h0000_00CA, 1'b0};
    vec[14] = '{1'b1, 3'b010, 32'h2000_0000, 32'h0102_0304, 32'h0, 1'b0};
    vec[15] = '{1'b1, 3'b010, 32'h2000_0030, 32'h1234_5678, 32'h0, 1'b0};
    vec[16] = '{1'b1, 3'b010, 32'h2000_0002, 32'hA5A5_A5A5, 32'h0, ERR};
    vec[17] = '{1'b0, 3'b010, 32'h2000_0000, 32'h0, ERR ? 32'h0102_0304 : 32'hA5A5_A5A5, 1'b0};
    vec[18] = '{1'b0, 3'b010, 32'h1FFF_FFFC, 32'h0, ERR ? 32'h0 : 32'hCAFE_F00D, ERR};
    vec[19] = '{1'b0, 3'b011, 32'h2000_0010, 32'h0, ERR ? 32'h0 : 32'hDEAD_BEEF, ERR};
    vec[20] = '{1'b0, 3'b001, 32'h2000_0023, 32'h0, ERR ? 32'h0 : 32'h0000_11AA, ERR};
    vec[21] = '{1'b0, 3'b010, 32'h2000_1000, 32'h0, ERR ? 32'h0 : 32'hA5A5_A5A5, ERR};
    repeat (3) @(negedge clk);
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_bdone", {31'h0, bdone}, 32'h0);
    chk("reset_berr", {31'h0, berr}, 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 22; i++) xact(vec[i]);
    // Held bstart through RESP must give one pulse; the next IDLE cycle accepts anew.
    @(negedge clk);
    issue(1'b0, 3'b010, 32'h2000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1);
    wait_done();
    @(negedge clk);
    chk("gap_bdone", {31'h0, bdone}, 32'h0);
    chk("gap_rdata", rdata, 32'hDEAD_BEEF);
    issue(1'b0, 3'b010, 32'h2000_0020, 32'h0, 32'h11AA_3344, 1'b0, 1'b1);
    wait_done();
    bstart = 1'b0;
    @(negedge clk);
    chk("single_pulse", {31'h0, bdone}, 32'h0);
    // breq low blocks acceptance.
    issue(1'b0, 3'b000, 32'h2000_0020, 32'h0, 32'h0, 1'b0, 1'b0);
    breq = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("no_breq_bdone", {31'h0, bdone}, 32'h0);
    end
    breq = 1'b1;
    sb.push_back('{32'h0000_0044, 1'b0, cyc});
    wait_done();
    bstart = 1'b0;
    // Reset in BUSY aborts an uncommitted write.
    @(negedge clk);
    issue(1'b1, 3'b010, 32'h2000_0030, 32'h0BAD_F00D, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0; bstart = 1'b0;
    #1 chk("abort_bdone", {31'h0, bdone}, 32'h0);
    chk("abort_rdata", rdata, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_reset_bdone", {31'h0, bdone}, 32'h0);
    end
    xact('{1'b0, 3'b010, 32'h2000_0030, 32'h0, 32'h1234_5678, 1'b0});
    lat_run(0, 1'b1, 32'h0000_0077, 32'h0);
    lat_run(0, 1'b0, 32'h0, 32'h0000_0077);
    lat_run(3, 1'b1, 32'h0000_0099, 32'h0);
    lat_run(3, 1'b0, 32'h0, 32'h0000_0099);
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
